// File: rtl/mem_arbiter_if.sv
// Request-side and RAM-side signals of the memory arbiter, bundled as one bus.
// The slave view belongs to the arbiter; the master view belongs to the datapath/RAM environment.
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        ihit;
  logic [31:0] iload;
  logic        dhit;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        memerr;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serializes instruction fetches and data loads/stores onto a single-port RAM.
// Data wins arbitration unless instruction fetch has waited IFAIR_MAX data grants.
module mem_arbiter #(
  parameter int IFAIR_MAX = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic         CLK,
  input  logic         nRST,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;
  localparam logic [3:0] FAIR_LIM   = 4'(IFAIR_MAX);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [3:0]  faircnt_reg, faircnt_next;
  logic [7:0]  tocnt_reg, tocnt_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] data_reg, data_next;
  logic        wr_reg, wr_next;
  logic        memerr_reg, memerr_next;

  logic        busy;
  logic        done;
  logic        abort;
  logic        dreq;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg   <= IDLE;
      faircnt_reg <= '0;
      tocnt_reg   <= '0;
      addr_reg    <= '0;
      data_reg    <= '0;
      wr_reg      <= 1'b0;
      memerr_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      faircnt_reg <= faircnt_next;
      tocnt_reg   <= tocnt_next;
      addr_reg    <= addr_next;
      data_reg    <= data_next;
      wr_reg      <= wr_next;
      memerr_reg  <= memerr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    faircnt_next = faircnt_reg;
    tocnt_next   = tocnt_reg;
    addr_next    = addr_reg;
    data_next    = data_reg;
    wr_next      = wr_reg;
    memerr_next  = memerr_reg;

    busy  = (state_reg != IDLE);
    dreq  = bus.dREN | bus.dWEN;
    done  = busy && (bus.ramstate == RAM_ACCESS);
    // A completing access takes precedence over a timeout landing on the same cycle.
    abort = busy && !done && ((bus.ramstate == RAM_ERROR) || (tocnt_reg == TO_LAST));

    case (state_reg)
      IDLE: begin
        if (dreq && (!bus.iREN || (faircnt_reg < FAIR_LIM))) begin
          state_next = DACC;
          addr_next  = bus.daddr;
          data_next  = bus.dstore;
          wr_next    = bus.dWEN;
          tocnt_next = '0;
          if (bus.iREN) begin
            faircnt_next = (faircnt_reg == 4'hF) ? faircnt_reg : faircnt_reg + 4'd1;
          end else begin
            faircnt_next = '0;
          end
        end else if (bus.iREN) begin
          state_next   = IACC;
          addr_next    = bus.iaddr;
          data_next    = '0;
          wr_next      = 1'b0;
          tocnt_next   = '0;
          faircnt_next = '0;
        end
      end
      default: begin
        if (done || abort) begin
          state_next = IDLE;
        end else begin
          tocnt_next = tocnt_reg + 8'd1;
        end
        if (abort) begin
          memerr_next = 1'b1;
        end
      end
    endcase
  end

  // RAM side is driven purely from registered state, never from live requests.
  assign bus.ramREN   = busy && !wr_reg;
  assign bus.ramWEN   = busy && wr_reg;
  assign bus.ramaddr  = busy ? addr_reg : '0;
  assign bus.ramstore = busy ? data_reg : '0;

  assign bus.dhit   = done && (state_reg == DACC);
  assign bus.ihit   = done && (state_reg == IACC);
  assign bus.dload  = (bus.dhit && !wr_reg) ? bus.ramload : '0;
  assign bus.iload  = bus.ihit ? bus.ramload : '0;
  assign bus.memerr = memerr_reg;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter, checked every cycle against a
// transaction-level model of the arbitration, completion and abort rules.
module tb_mem_arbiter;
  localparam int IFAIR_MAX = 4;
  localparam int TIMEOUT   = 64;

  logic CLK = 1'b0;
  logic nRST = 1'b0;

  mem_arbiter_if bus();

  mem_arbiter #(.IFAIR_MAX(IFAIR_MAX), .TIMEOUT(TIMEOUT)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  // Transaction-level model: either idle or carrying one latched request.
  bit          m_busy = 1'b0;
  bit          m_isdata = 1'b0;
  bit          m_wr = 1'b0;
  bit          m_err = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_data = '0;
  int          m_wait = 0;
  int          m_fair = 0;

  always @(negedge CLK) begin
    if (!nRST) begin
      m_busy = 1'b0;
      m_fair = 0;
      m_err  = 1'b0;
      m_wait = 0;
      chk1 ("rst_ramREN",   bus.ramREN,   1'b0);
      chk1 ("rst_ramWEN",   bus.ramWEN,   1'b0);
      chk32("rst_ramaddr",  bus.ramaddr,  32'h0);
      chk32("rst_ramstore", bus.ramstore, 32'h0);
      chk1 ("rst_ihit",     bus.ihit,     1'b0);
      chk1 ("rst_dhit",     bus.dhit,     1'b0);
      chk32("rst_iload",    bus.iload,    32'h0);
      chk32("rst_dload",    bus.dload,    32'h0);
      chk1 ("rst_memerr",   bus.memerr,   1'b0);
    end else begin
      logic        hit_now;
      logic        e_dhit;
      logic        e_ihit;
      hit_now = m_busy && (bus.ramstate == 2'd2);
      e_dhit  = hit_now && m_isdata;
      e_ihit  = hit_now && !m_isdata;
      chk1 ("ramREN",  bus.ramREN,  m_busy && !m_wr);
      chk1 ("ramWEN",  bus.ramWEN,  m_busy && m_wr);
      chk32("ramaddr", bus.ramaddr, m_busy ? m_addr : 32'h0);
      if (!m_busy || m_wr)
        chk32("ramstore", bus.ramstore, m_busy ? m_data : 32'h0);
      chk1 ("dhit",    bus.dhit,    e_dhit);
      chk1 ("ihit",    bus.ihit,    e_ihit);
      chk32("dload",   bus.dload,   (e_dhit && !m_wr) ? bus.ramload : 32'h0);
      chk32("iload",   bus.iload,   e_ihit ? bus.ramload : 32'h0);
      chk1 ("memerr",  bus.memerr,  m_err);

      if (!m_busy) begin
        if ((bus.dREN || bus.dWEN) && (!bus.iREN || m_fair < IFAIR_MAX)) begin
          m_busy   = 1'b1;
          m_isdata = 1'b1;
          m_wr     = bus.dWEN;
          m_addr   = bus.daddr;
          m_data   = bus.dstore;
          m_wait   = 0;
          m_fair   = bus.iREN ? m_fair + 1 : 0;
        end else if (bus.iREN) begin
          m_busy   = 1'b1;
          m_isdata = 1'b0;
          m_wr     = 1'b0;
          m_addr   = bus.iaddr;
          m_wait   = 0;
          m_fair   = 0;
        end
      end else begin
        m_wait++;
        if (bus.ramstate == 2'd2) begin
          m_busy = 1'b0;
          n_txn++;
          $display("txn %0d: %s %s addr=%h data=%h cycles=%0d", n_txn, m_isdata ? "D" : "I",
                   m_wr ? "wr" : "rd", m_addr, m_wr ? m_data : bus.ramload, m_wait);
        end else if (bus.ramstate == 2'd3 || m_wait == TIMEOUT) begin
          m_busy = 1'b0;
          m_err  = 1'b1;
          n_txn++;
          $display("txn %0d: %s abort addr=%h cycles=%0d (%s)", n_txn, m_isdata ? "D" : "I",
                   m_addr, m_wait, (bus.ramstate == 2'd3) ? "ram error" : "timeout");
        end
      end
    end
  end

  task automatic mid();
    @(negedge CLK);
    #1;
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  logic [11:0] seq;
  int          nhits;
  int          busy_left;

  initial begin
    bus.iREN = 1'b0; bus.iaddr = '0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ramstate = 2'd0;
    nRST = 1'b0;
    repeat (2) nxt();
    chk1("reset_memerr", bus.memerr, 1'b0);
    chk1("reset_ramREN", bus.ramREN, 1'b0);
    nRST = 1'b1;

    // Instruction fetch, RAM answers on the third access cycle.
    bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = 2'd0;
    mid(); chk1("t1_idle_ren", bus.ramREN, 1'b0);
    nxt(); bus.iREN = 1'b0; bus.ramstate = 2'd1;
    mid(); chk1("t1_c1_ren", bus.ramREN, 1'b1); chk32("t1_c1_addr", bus.ramaddr, 32'h40);
    chk1("t1_c1_ihit", bus.ihit, 1'b0);
    nxt();
    mid(); chk1("t1_c2_ren", bus.ramREN, 1'b1);
    nxt(); bus.ramstate = 2'd2; bus.ramload = 32'h8C220004;
    mid(); chk1("t1_ihit", bus.ihit, 1'b1); chk32("t1_iload", bus.iload, 32'h8C220004);
    chk1("t1_c3_ren", bus.ramREN, 1'b1);
    nxt(); bus.ramstate = 2'd0;
    mid(); chk1("t1_after_ihit", bus.ihit, 1'b0); chk1("t1_after_ren", bus.ramREN, 1'b0);

    // Simultaneous fetch and store: store goes first.
    nxt(); bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.dWEN = 1'b1; bus.daddr = 32'h100;
    bus.dstore = 32'hDEADBEEF; bus.ramload = 32'h12345678;
    mid(); chk1("t2_idle_wen", bus.ramWEN, 1'b0);
    nxt(); bus.ramstate = 2'd2;
    mid(); chk1("t2_wen", bus.ramWEN, 1'b1); chk1("t2_ren", bus.ramREN, 1'b0);
    chk32("t2_store", bus.ramstore, 32'hDEADBEEF); chk32("t2_addr", bus.ramaddr, 32'h100);
    chk1("t2_dhit", bus.dhit, 1'b1); chk32("t2_dload", bus.dload, 32'h0); chk1("t2_no_ihit", bus.ihit, 1'b0);
    nxt(); bus.dWEN = 1'b0; bus.ramstate = 2'd0;
    mid(); chk1("t2_gap_ren", bus.ramREN, 1'b0); chk1("t2_gap_wen", bus.ramWEN, 1'b0);
    nxt(); bus.ramstate = 2'd2; bus.ramload = 32'hCAFEF00D;
    mid(); chk1("t2_ihit", bus.ihit, 1'b1); chk32("t2_iload", bus.iload, 32'hCAFEF00D);
    chk32("t2_iaddr", bus.ramaddr, 32'h44);
    nxt(); bus.iREN = 1'b0; bus.ramstate = 2'd0;
    mid();

    // Fairness: continuous data and fetch requests, RAM always ready.
    nxt(); bus.iREN = 1'b1; bus.dREN = 1'b1; bus.daddr = 32'h300; bus.iaddr = 32'h48; bus.ramstate = 2'd2;
    seq = '0; nhits = 0;
    for (int c = 0; c < 24; c++) begin
      bus.ramload = $urandom;
      mid();
      if (bus.dhit || bus.ihit) begin
        seq = {seq[10:0], bus.ihit};
        nhits++;
      end
      nxt();
    end
    chk32("t3_hits", 32'(nhits), 32'd12);
    chk32("t3_pattern", {20'h0, seq}, {20'h0, 12'b000010000100});
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.ramstate = 2'd0;
    mid();

    // RAM error aborts and latches memerr.
    nxt(); bus.dREN = 1'b1; bus.daddr = 32'h200;
    mid();
    nxt(); bus.dREN = 1'b0; bus.ramstate = 2'd3;
    mid(); chk1("t4_err_dhit", bus.dhit, 1'b0); chk1("t4_err_memerr_pre", bus.memerr, 1'b0);
    chk1("t4_err_ren", bus.ramREN, 1'b1);
    nxt(); bus.ramstate = 2'd0;
    mid(); chk1("t4_memerr", bus.memerr, 1'b1); chk1("t4_idle_ren", bus.ramREN, 1'b0);
    nxt(); bus.dREN = 1'b1;
    mid();
    nxt(); bus.dREN = 1'b0; bus.ramstate = 2'd2; bus.ramload = 32'h0BADF00D;
    mid(); chk1("t4_ok_dhit", bus.dhit, 1'b1); chk32("t4_ok_dload", bus.dload, 32'h0BADF00D);
    chk1("t4_ok_memerr", bus.memerr, 1'b1);
    nxt(); bus.ramstate = 2'd0;
    mid(); chk1("t4_sticky", bus.memerr, 1'b1);

    // Asynchronous reset in the middle of a fetch.
    nxt(); bus.iREN = 1'b1; bus.iaddr = 32'h80;
    mid();
    nxt(); bus.iREN = 1'b0; bus.ramstate = 2'd1;
    mid(); chk1("t6_pre_ren", bus.ramREN, 1'b1); chk1("t6_pre_memerr", bus.memerr, 1'b1);
    #1 nRST = 1'b0; bus.ramstate = 2'd2;
    #1 chk1("t6_rst_ren", bus.ramREN, 1'b0); chk1("t6_rst_ihit", bus.ihit, 1'b0);
    chk1("t6_rst_memerr", bus.memerr, 1'b0);
    nxt(); nxt();
    bus.ramstate = 2'd0; nRST = 1'b1;
    mid(); chk1("t6_post_ren", bus.ramREN, 1'b0); chk1("t6_post_memerr", bus.memerr, 1'b0);

    // Hung RAM: abort on the TIMEOUT-th access cycle, then serve the pending fetch.
    nxt(); bus.dREN = 1'b1; bus.daddr = 32'h204;
    mid();
    nxt(); bus.dREN = 1'b0; bus.iREN = 1'b1; bus.iaddr = 32'h84; bus.ramstate = 2'd1;
    for (int c = 1; c <= TIMEOUT; c++) begin
      mid();
      if (c >= TIMEOUT - 1) chk1("t5_ren_hold", bus.ramREN, 1'b1);
      if (c == TIMEOUT) chk1("t5_memerr_pre", bus.memerr, 1'b0);
      nxt();
    end
    mid(); chk1("t5_memerr", bus.memerr, 1'b1); chk1("t5_idle_ren", bus.ramREN, 1'b0);
    nxt();
    mid(); chk1("t5_next_ren", bus.ramREN, 1'b1); chk32("t5_next_addr", bus.ramaddr, 32'h84);
    nxt(); bus.ramstate = 2'd2;
    mid(); chk1("t5_next_ihit", bus.ihit, 1'b1);
    nxt(); bus.iREN = 1'b0; bus.ramstate = 2'd0;

    // Random traffic with occasional resets and hung-RAM bursts.
    busy_left = 0;
    for (int c = 0; c < 4000; c++) begin
      nRST = ($urandom_range(0, 599) != 0);
      if (busy_left == 0 && $urandom_range(0, 399) == 0) busy_left = 70;
      if (busy_left > 0) begin
        bus.ramstate = 2'd1;
        busy_left--;
      end else begin
        int r;
        r = $urandom_range(0, 9);
        bus.ramstate = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      end
      bus.iREN    = ($urandom_range(0, 2) != 0);
      bus.dREN    = ($urandom_range(0, 1) != 0);
      bus.dWEN    = ($urandom_range(0, 3) == 0);
      bus.iaddr   = $urandom;
      bus.daddr   = $urandom;
      bus.dstore  = $urandom;
      bus.ramload = $urandom;
      nxt();
    end
    nRST = 1'b1;
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Memory-side responder to the request unit. Accepts instruction-fetch and data load/store requests and serializes them onto the single-port RAM.
- Returns ihit/dhit pulses with load data.
- Sits between the datapath/request unit and the RAM model.
- Data has priority. A fairness counter keeps instruction fetch from starving, and a timeout guards against a hung RAM.

Parameters:
- IFAIR_MAX, default 4: max consecutive data grants while iREN is pending before one instruction grant is forced (range 1..15).
- TIMEOUT, default 64: cycles a granted access may wait for RAM ACCESS before it is aborted (range 2..255).

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request
- iaddr  in  32  instruction address
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  data write value
- ihit  out  1  instruction access complete, one-cycle pulse
- iload  out  32  instruction word, valid when ihit=1
- dhit  out  1  data access complete, one-cycle pulse
- dload  out  32  data word, valid when dhit=1 for a read
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  0=FREE, 1=BUSY, 2=ACCESS, 3=ERROR
- memerr  out  1  sticky error flag; cleared only by reset

Behaviour:
- One clock (CLK). Reset nRST is asynchronous and active-low.
- Reset values: state=IDLE, fair counter=0, timeout counter=0, latched addr/data/op=0, memerr=0. All outputs are 0 while in reset.
- FSM states: IDLE, DACC, IACC.
- IDLE arbitration, evaluated every cycle:
  - If (dREN|dWEN) and (!iREN or faircnt<IFAIR_MAX): grant data. Go to DACC. If iREN=1, faircnt++ (saturating); otherwise faircnt=0.
  - Else if iREN: grant instruction. Go to IACC. faircnt=0.
  - Else: stay in IDLE.
- On grant, register the address, store data and op (write if dWEN, else read). dWEN wins over dREN when both are high.
- DACC/IACC: drive ramaddr and ramstore from the latched values. ramWEN = latched write, ramREN = latched read. Inputs are ignored until return to IDLE.
- RAM outputs are 0 in IDLE, so there is no combinational path from requests to the RAM.
- Completion: ramstate==ACCESS in DACC/IACC. In that same cycle:
  - dhit/ihit=1 (combinational).
  - dload/iload=ramload; the load bus reads 0 when the corresponding hit is 0.
  - Next state is IDLE.
  - A write also pulses dhit; dload=0 for a write.
- FREE/BUSY in DACC/IACC: hold state. tocnt increments each cycle.
- ERROR in DACC/IACC: abort. No hit is asserted, memerr<=1, next state is IDLE.
- Timeout: when tocnt reaches TIMEOUT-1 without ACCESS, abort as for ERROR. tocnt clears on every entry to DACC/IACC.
- Requester drops its request mid-access: the latched transaction still completes and still pulses hit. In-flight writes are never cancelled.
- Minimum access is 2 cycles: grant in IDLE, then hit in DACC/IACC on the first cycle ramstate==ACCESS. There is always at least one IDLE cycle between accesses.
- A requester still asserting its request in the IDLE cycle after its hit is re-granted. Requesters drop the request within one cycle of the hit; a repeated read or write to the same address is architecturally harmless.
- nRST asserted mid-access: immediate return to reset values. The RAM enables drop asynchronously.

Test Plan:
- iREN=1, iaddr=0x40, RAM returns ACCESS on 3rd DACC/IACC cycle with ramload=0x8C220004 -> ramREN=1, ramaddr=0x40 for 3 cycles; ihit=1 for exactly one cycle with iload=0x8C220004; then IDLE.
- iREN=1 and dWEN=1 simultaneously, daddr=0x100, dstore=0xDEADBEEF -> data granted first; ramWEN=1, ramstore=0xDEADBEEF; dhit pulses, dload=0; instruction granted at the next IDLE, ihit follows.
- dREN held high continuously with iREN high, IFAIR_MAX=4 -> exactly 4 dhits, then 1 ihit, then the data pattern resumes; faircnt resets after the forced ihit.
- ramstate=ERROR during DACC -> no dhit; memerr=1 and stays 1 across later successful accesses until nRST.
- ramstate stuck BUSY, TIMEOUT=64 -> abort on the 64th DACC/IACC cycle; memerr=1; the next pending request is granted afterwards.
- nRST pulsed low during IACC with ramREN=1 -> ramREN, ihit, memerr=0 immediately; state=IDLE after release.
